// File: rtl/elastic_pipe_pkg.sv
// Shared types and helpers for the elastic pipeline.
package elastic_pipe_pkg;

  // Performance counters exposed when ELASTIC_PIPE_PERF_EN is defined.
  typedef struct packed {
    logic [31:0] stall;
    logic [31:0] full;
  } pipe_perf_t;

  // Width of the occupancy counter for a pipe of the given depth (0..2*depth).
  function automatic int unsigned pipe_count_w(input int unsigned depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/elastic_stage.sv
// One elastic stage: main register plus skid register. The upstream ready is
// taken straight from the skid valid flop, so no ready path crosses the stage.
module elastic_stage #(
  parameter int unsigned      WIDTH = 32,
  parameter logic [WIDTH-1:0] NOP   = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             accept;
  logic             drain;

  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_valid_q ? main_data_q : NOP;

  // Next-state: fill main when empty or draining, else park in skid; refill main from skid.
  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;
    accept       = in_valid & ~skid_valid_q;
    drain        = main_valid_q & out_ready;
    if (drain) begin
      if (skid_valid_q) begin
        // accept is impossible here because in_ready is low while skid is full
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_data_d = in_data;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
      end
    end
  end

  // Valid bits: cleared by reset or flush.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  // Payload registers carry no reset; they are qualified by the valid bits.
  always_ff @(posedge clk) begin
    main_data_q <= main_data_d;
    skid_data_q <= skid_data_d;
  end

endmodule

// File: rtl/elastic_pipe.sv
// Elastic pipeline: chain of DEPTH elastic_stage instances with an occupancy
// counter. Optional perf counters are enabled by defining ELASTIC_PIPE_PERF_EN.
module elastic_pipe
  import elastic_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH = 32,
  parameter int unsigned      DEPTH = 2,
  parameter logic [WIDTH-1:0] NOP   = '0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WIDTH-1:0]                in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [WIDTH-1:0]                out_data,
  input  logic                            flush,
  output logic [pipe_count_w(DEPTH)-1:0]  count
`ifdef ELASTIC_PIPE_PERF_EN
  ,
  output logic [31:0]                     perf_stall,
  output logic [31:0]                     perf_full
`endif
);

  localparam int unsigned CW = pipe_count_w(DEPTH);

  logic             stage_valid [DEPTH+1];
  logic             stage_ready [DEPTH+1];
  logic [WIDTH-1:0] stage_data  [DEPTH+1];

  logic [CW-1:0] count_q, count_d;
  logic          in_xfer;
  logic          out_xfer;
  logic          full;

  assign stage_valid[0]     = in_valid;
  assign stage_data[0]      = in_data;
  assign stage_ready[DEPTH] = out_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    elastic_stage #(
      .WIDTH (WIDTH),
      .NOP   (NOP)
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (stage_valid[k]),
      .in_ready  (stage_ready[k]),
      .in_data   (stage_data[k]),
      .out_valid (stage_valid[k+1]),
      .out_ready (stage_ready[k+1]),
      .out_data  (stage_data[k+1])
    );
  end

  // Boundary handshake: reset and flush hide the pipe from both neighbours.
  always_comb begin
    in_ready  = stage_ready[0] & ~reset & ~flush;
    out_valid = stage_valid[DEPTH] & ~reset & ~flush;
    out_data  = out_valid ? stage_data[DEPTH] : NOP;
    in_xfer   = in_valid & in_ready;
    out_xfer  = out_valid & out_ready;
    full      = (count_q == CW'(2 * DEPTH));
    count     = reset ? '0 : count_q;
    count_d   = count_q + CW'(in_xfer) - CW'(out_xfer);
  end

  // Occupancy counter tracks accepted minus delivered beats.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

`ifdef ELASTIC_PIPE_PERF_EN
  pipe_perf_t perf_q, perf_d;
  logic       stall;

  // Saturating perf counters; flush does not touch them.
  always_comb begin
    perf_d = perf_q;
    stall  = out_valid & ~out_ready;
    if (stall && (perf_q.stall != '1)) perf_d.stall = perf_q.stall + 32'd1;
    if (full && (perf_q.full != '1))   perf_d.full  = perf_q.full + 32'd1;
  end

  // Perf counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_stall = perf_q.stall;
  assign perf_full  = perf_q.full;
`else
  logic unused_full;
  assign unused_full = full;
`endif

endmodule

// File: tb/tb_elastic_pipe.sv
// Scoreboard bench for elastic_pipe (WIDTH=8, DEPTH=2, NOP=8'h13).
module tb_elastic_pipe;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 2;
  localparam logic [7:0]  NOP   = 8'h13;
  localparam int unsigned CW    = $clog2(2 * DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [7:0]    in_data, out_data;
  logic [CW-1:0] count;
`ifdef ELASTIC_PIPE_PERF_EN
  logic [31:0]   perf_stall, perf_full;
  logic [31:0]   s_stall, s_full, p_stall0, p_full0;
`endif

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  int model_count = 0;
  logic [7:0] exp_q[$];

  logic          acc;
  logic          s_in_ready, s_out_valid;
  logic [7:0]    s_out_data;
  logic [CW-1:0] s_count;

  elastic_pipe #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .NOP   (NOP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .count     (count)
`ifdef ELASTIC_PIPE_PERF_EN
    ,
    .perf_stall (perf_stall),
    .perf_full  (perf_full)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle; sample outputs on the falling edge and record accepted beats.
  task automatic step(input logic v, input logic [7:0] d, input logic ordy);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    @(negedge clk);
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    s_out_data  = out_data;
    s_count     = count;
`ifdef ELASTIC_PIPE_PERF_EN
    s_stall = perf_stall;
    s_full  = perf_full;
`endif
    acc = v && in_ready;
    if (acc) exp_q.push_back(d);
    @(posedge clk);
    #1;
  endtask

  // Offer beats with out_ready low until n are accepted.
  task automatic fill(input int n, input logic [7:0] base);
    int got = 0;
    logic [7:0] d = base;
    for (int i = 0; i < 20 && got < n; i++) begin
      step(1'b1, d, 1'b0);
      if (acc) begin
        got++;
        d++;
      end
    end
    check("fill_accepted", got, n);
  endtask

  // Drain with out_ready high until empty, bounded.
  task automatic drain(input string name);
    int i;
    for (i = 0; i < 30; i++) begin
      step(1'b0, 8'h00, 1'b1);
      if (s_count == 0 && !s_out_valid) break;
    end
    check({name, "_drained"}, (i < 30) ? 1 : 0, 1);
    check({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  // Monitor: pops expected beats on output transfers and tracks occupancy.
  always @(negedge clk) begin
    logic [7:0] e;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected: got %0h expected no output", out_data);
      end else begin
        e = exp_q.pop_front();
        check("out_order", out_data, e);
        pops++;
      end
    end
    if (!out_valid) check("nop_idle", out_data, NOP);
    check("count_model", count, reset ? 0 : model_count);
    if (model_count == 2 * DEPTH) check("full_not_ready", in_ready, 0);
    if (reset || flush) begin
      exp_q.delete();
      model_count = 0;
    end else begin
      model_count = model_count + ((in_valid && in_ready) ? 1 : 0)
                                - ((out_valid && out_ready) ? 1 : 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    int nacc, pops0, i;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    step(1'b1, 8'h77, 1'b1);
    check("rst_in_ready", s_in_ready, 0);
    check("rst_out_valid", s_out_valid, 0);
    check("rst_out_data", s_out_data, NOP);
    check("rst_count", s_count, 0);
    reset = 1'b0;
    step(1'b0, 8'h00, 1'b1);
    check("post_rst_in_ready", s_in_ready, 1);

    // Streaming 01..10, out_ready=1
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 8'(k + 1), 1'b1);
      check("stream_accept", acc, 1);
      if (k < 2) begin
        check("stream_latency", s_out_valid, 0);
      end else begin
        check("stream_no_bubble", s_out_valid, 1);
        check("stream_data", s_out_data, 8'(k - 1));
        check("stream_count", s_count, 2);
      end
    end
    step(1'b0, 8'h00, 1'b1);
    check("stream_tail0", s_out_data, 8'h0f);
    step(1'b0, 8'h00, 1'b1);
    check("stream_tail1", s_out_data, 8'h10);
    drain("stream");

    // Back-pressure fill: 6 offered, 4 accepted
    nacc = 0;
    d = 8'h21;
    for (int k = 0; k < 6; k++) begin
      step(1'b1, d, 1'b0);
      if (acc) begin
        nacc++;
        d++;
      end
    end
    check("bp_accepted", nacc, 4);
    step(1'b0, 8'h00, 1'b0);
    check("bp_in_ready", s_in_ready, 0);
    check("bp_count", s_count, 4);
    pops0 = pops;
    drain("bp");
    check("bp_outputs", pops - pops0, 4);
    check("bp_in_ready_after", s_in_ready, 1);

    // Random valid/ready
    d = 8'h00;
    for (int k = 0; k < 2000; k++) begin
      step(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)));
      if (acc) d++;
    end
    drain("rand");

    // Flush with count=3
    fill(3, 8'h31);
    step(1'b0, 8'h00, 1'b0);
    check("fl_count3", s_count, 3);
    flush = 1'b1;
    step(1'b1, 8'h55, 1'b1);
    check("fl_in_ready", s_in_ready, 0);
    check("fl_out_valid", s_out_valid, 0);
    flush = 1'b0;
    step(1'b0, 8'h00, 1'b1);
    check("fl_count0", s_count, 0);
    check("fl_in_ready_back", s_in_ready, 1);
    step(1'b1, 8'hAA, 1'b1);
    check("fl_aa_accept", acc, 1);
    for (i = 0; i < 10; i++) begin
      step(1'b0, 8'h00, 1'b1);
      if (s_out_valid) break;
    end
    check("fl_aa_seen", (i < 10) ? 1 : 0, 1);
    check("fl_aa_data", s_out_data, 8'hAA);
    drain("fl");

    // Reset mid-stream with count=4
    fill(4, 8'h41);
    step(1'b0, 8'h00, 1'b0);
    check("mr_count4", s_count, 4);
    reset = 1'b1;
    step(1'b1, 8'h66, 1'b1);
    check("mr_in_ready", s_in_ready, 0);
    check("mr_out_valid", s_out_valid, 0);
    check("mr_out_data", s_out_data, NOP);
    check("mr_count", s_count, 0);
    reset = 1'b0;
    step(1'b0, 8'h00, 1'b1);
    check("mr_in_ready_after", s_in_ready, 1);
    check("mr_count_after", s_count, 0);
    check("mr_out_valid_after", s_out_valid, 0);
`ifdef ELASTIC_PIPE_PERF_EN
    check("mr_perf_stall", s_stall, 0);

    // Perf: hold full for 10 cycles
    fill(4, 8'h51);
    step(1'b0, 8'h00, 1'b0);
    check("pf_count4", s_count, 4);
    p_full0  = s_full;
    p_stall0 = s_stall;
    for (int k = 0; k < 10; k++) step(1'b0, 8'h00, 1'b0);
    check("pf_full_delta", s_full - p_full0, 10);
    check("pf_stall_delta", (s_stall - p_stall0 >= 10) ? 1 : 0, 1);
    drain("pf");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
